// File: rtl/load_store_unit.sv
// load_store_unit: CPU byte/half/word loads and stores at any byte address onto a word-wide RAM port.
// Latency: resp_valid 2 cycles after the accept edge, 3 when the access straddles a word boundary.
// Backpressure: req_ready is low from accept through the response cycle; a held request waits for IDLE.
module load_store_unit #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wenable,
  input  logic [31:0]           mem_rdata
);

  localparam int WORD_W = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Latched request. size_q is normalised so 3 never appears (3 behaves as word).
  logic              write_q;
  logic              unsigned_q;
  logic [1:0]        size_q;
  logic [1:0]        off_q;
  logic [WORD_W-1:0] waddr_q;
  logic [31:0]       wdata_q;

  // Load capture. Only the low three bytes of the second word can ever reach
  // the result (offset is at most 3), so the top byte is not kept.
  logic [31:0]       lo_buf_q;
  logic [23:0]       hi_buf_q;

  logic              accept;
  logic [1:0]        size_norm;
  logic [31:0]       wdata_trim;

  logic [3:0]        size_mask;
  logic [2:0]        nbytes;
  logic [7:0]        lane_mask;
  logic [63:0]       lanes;
  logic              crosses;
  logic [WORD_W-1:0] waddr_next;
  logic [31:0]       raw;
  logic [31:0]       load_data;

  // Address bits above the RAM size are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH];

  assign accept = (state_q == IDLE) && req_valid;

  // Normalise size and clear store bytes beyond the access width so that the
  // shifted lanes carry zero wherever the byte enable is low.
  always_comb begin
    size_norm  = (req_size == 2'd3) ? 2'd2 : req_size;
    wdata_trim = req_wdata;
    case (req_size)
      2'd0:    wdata_trim = {24'h0, req_wdata[7:0]};
      2'd1:    wdata_trim = {16'h0, req_wdata[15:0]};
      default: wdata_trim = req_wdata;
    endcase
  end

  // Byte-lane geometry of the latched request across the two candidate words.
  always_comb begin
    size_mask = 4'b1111;
    nbytes    = 3'd4;
    case (size_q)
      2'd0: begin
        size_mask = 4'b0001;
        nbytes    = 3'd1;
      end
      2'd1: begin
        size_mask = 4'b0011;
        nbytes    = 3'd2;
      end
      default: begin
        size_mask = 4'b1111;
        nbytes    = 3'd4;
      end
    endcase
    lane_mask  = {4'b0000, size_mask} << off_q;
    lanes      = {32'h0, wdata_q} << {off_q, 3'b000};
    crosses    = ({1'b0, off_q} + nbytes) > 3'd4;
    waddr_next = waddr_q + WORD_W'(1);
  end

  // Realign the captured words to the requested offset, then extend.
  always_comb begin
    raw = lo_buf_q;
    case (off_q)
      2'd0:    raw = lo_buf_q;
      2'd1:    raw = {hi_buf_q[7:0],  lo_buf_q[31:8]};
      2'd2:    raw = {hi_buf_q[15:0], lo_buf_q[31:16]};
      default: raw = {hi_buf_q[23:0], lo_buf_q[31:24]};
    endcase
    load_data = raw;
    case (size_q)
      2'd0:    load_data = {{24{~unsigned_q & raw[7]}},  raw[7:0]};
      2'd1:    load_data = {{16{~unsigned_q & raw[15]}}, raw[15:0]};
      default: load_data = raw;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch, loaded only on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= 2'd0;
      off_q      <= 2'd0;
      waddr_q    <= '0;
      wdata_q    <= 32'h0;
    end else if (accept) begin
      write_q    <= req_write;
      unsigned_q <= req_unsigned;
      size_q     <= size_norm;
      off_q      <= req_addr[1:0];
      waddr_q    <= req_addr[ADDR_WIDTH-1:2];
      wdata_q    <= wdata_trim;
    end
  end

  // Load beat capture; the second-word buffer is cleared at accept so a
  // single-beat load assembles with zeros above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_buf_q <= 32'h0;
      hi_buf_q <= 24'h0;
    end else if (accept) begin
      lo_buf_q <= 32'h0;
      hi_buf_q <= 24'h0;
    end else if (!write_q && (state_q == LO)) begin
      lo_buf_q <= mem_rdata;
    end else if (!write_q && (state_q == HI)) begin
      hi_buf_q <= mem_rdata[23:0];
    end
  end

  // Next state and all outputs, decoded from state and latched request only.
  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_rdata  = 32'h0;
    mem_addr    = '0;
    mem_wdata   = 32'h0;
    mem_wenable = 4'b0000;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = LO;
        end
      end
      LO: begin
        mem_addr = {waddr_q, 2'b00};
        if (write_q) begin
          mem_wenable = lane_mask[3:0];
          mem_wdata   = lanes[31:0];
        end
        state_d = crosses ? HI : DONE;
      end
      HI: begin
        mem_addr = {waddr_next, 2'b00};
        if (write_q) begin
          mem_wenable = lane_mask[7:4];
          mem_wdata   = lanes[63:32];
        end
        state_d = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_rdata = write_q ? 32'h0 : load_data;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
